// File: rtl/bus_arbiter.sv
// bus_arbiter: four-master round-robin bus arbiter with registered one-hot grant.
// Master 0 is the CPU and masters 1..3 are peripherals/DMA.
// The IDLE -> GRANT -> HANDOVER FSM inserts one dead cycle between owners.
// The first GRANT cycle keeps oe low so the shared transceiver can turn around.
// Optional feature: define BUS_ARB_TIMEOUT_EN to add the forced-release hold counter.
// Without that macro, timeout is tied low and a master keeps the bus until it lets go.
module bus_arbiter #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic [3:0] lock,
   output logic [3:0] gnt,
   output logic [1:0] owner,
   output logic       oe,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HANDOVER} state_t;

   state_t     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] owner_q, owner_d;
   logic       oe_q, oe_d;
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] win;
   logic       owner_hold;
   logic       force_rel;

   // Round-robin pick: first set request at or after ptr, wrapping mod 4.
   always_comb begin
      logic found;
      logic [1:0] idx;
      win   = ptr_q;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   assign owner_hold = req[owner_q] | lock[owner_q];

`ifdef BUS_ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   logic [7:0] cnt_q, cnt_d;
   logic [3:0] own_mask;

   assign own_mask = 4'b0001 << owner_q;

   // Forced release: owner still requests but is unlocked, hold expired, someone else waits.
   assign force_rel = (state_q == S_GRANT) && req[owner_q] && !lock[owner_q] &&
                      (cnt_q == HOLD_MAX) && |(req & ~own_mask);

   // Hold counter: cleared on entry to GRANT, counts GRANT cycles, saturates at MAX_HOLD.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d == S_GRANT) begin
         if (state_q != S_GRANT)
            cnt_d = 8'd0;
         else if (cnt_q != HOLD_MAX)
            cnt_d = cnt_q + 8'd1;
      end
   end

   // Hold counter register.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= 8'd0;
      else       cnt_q <= cnt_d;
   end
`else
   assign force_rel = 1'b0;
`endif

   // Next-state and registered-output logic for the arbitration FSM.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      oe_d    = oe_q;
      ptr_d   = ptr_q;
      case (state_q)
         S_IDLE, S_HANDOVER: begin
            gnt_d = 4'b0000;
            oe_d  = 1'b0;
            if (|req) begin
               state_d = S_GRANT;
               owner_d = win;
               gnt_d   = 4'b0001 << win;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GRANT: begin
            if (!owner_hold || force_rel) begin
               // Releasing owner drops to lowest priority for the next pick.
               state_d = S_HANDOVER;
               gnt_d   = 4'b0000;
               oe_d    = 1'b0;
               ptr_d   = owner_q + 2'd1;
            end else begin
               oe_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
            oe_d    = 1'b0;
         end
      endcase
   end

   // State and output registers; reset wins from any state, with no handover cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         gnt_q   <= 4'b0000;
         owner_q <= 2'd0;
         oe_q    <= 1'b0;
         ptr_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         oe_q    <= oe_d;
         ptr_q   <= ptr_d;
      end
   end

   assign gnt     = gnt_q;
   assign owner   = owner_q;
   assign oe      = oe_q;
   assign busy    = (state_q != S_IDLE);
   assign timeout = force_rel;

endmodule
